rx_packet_ctrl: RTL and testbench
=================================

// Module: rx_packet_ctrl
// PURPOSE
//  Frame controller behind the RS232 receiver. Consumes its byte strobes (EOR, D, DVD).
//  Parses frames of the form SOF, LEN, LEN payload bytes, CHK. Payload goes into an
//  internal MAXLEN-deep buffer; the host drains it with a read handshake. Reports parity,
//  length, checksum and inter-byte timeout errors, and overrun, so upper logic only ever
//  sees whole, checked packets.
// PARAMETERS
//  MAXLEN   16         max payload bytes; buffer depth; legal LEN is 1..MAXLEN
//  AW       4          buffer address width, 2**AW >= MAXLEN
//  SOF      8'hAA      start-of-frame byte
//  TW       18         width of timeout counter
//  TIMEOUT  18'd168750 max CLK cycles between bytes inside a frame (~3 bytes @4800 baud)
// PORTS
//  CLK      in   1   system clock, all logic on rising edge
//  RST      in   1   synchronous reset, active-low (0 = reset)
//  EOR      in   1   receiver end-of-reception, level, may stay high for many CLKs
//  D        in   8   received byte, stable while EOR high
//  DVD      in   1   1 = parity of D correct
//  RD       in   1   host read request, one byte per cycle while PKT_RDY
//  Q        out  8   payload byte, registered
//  QV       out  1   Q valid strobe
//  PKT_RDY  out  1   complete checked packet held in buffer
//  LEN_OUT  out  8   payload length of held packet, valid while PKT_RDY
//  ERR      out  1   one-cycle error strobe
//  ERR_CODE out  2   00 timeout, 01 parity, 10 bad length, 11 checksum; held until next ERR
//  OVR      out  1   sticky: byte arrived while PKT_RDY; cleared when buffer fully read or on reset
// BEHAVIOUR
//  Reset (RST=0 at an edge): state=IDLE, all outputs 0, pointers/counters/EOR_d/acc cleared.
//    Reset mid-frame or mid-read discards everything.
//  Byte strobe: EOR_d <= EOR each cycle; STB = EOR & ~EOR_d.
//    D and DVD are sampled on the edge where STB=1. Exactly one byte per EOR rising edge.
//  Any STB with DVD=0 in LEN/PAY/CHK: ERR=1, code 01, ->IDLE.
//    Any STB with DVD=0 in IDLE: ignored, no ERR.
//  FSM (transitions on STB unless noted):
//    IDLE: D==SOF & DVD -> LEN; other bytes are ignored.
//    LEN:  1<=D<=MAXLEN -> store len, acc=D, wptr=0, -> PAY.
//          Otherwise ERR code 10, -> IDLE.
//    PAY:  buf[wptr]=D, acc^=D, wptr++. After the len-th byte -> CHK.
//    CHK:  D==acc -> READY, PKT_RDY=1 and LEN_OUT=len on the next cycle.
//          Otherwise ERR code 11, -> IDLE.
//    READY: any STB sets OVR=1; the byte is dropped; state unchanged.
//      RD=1: Q<=buf[rptr] and QV=1 on the next cycle, rptr++. Read latency is 1 cycle.
//      The cycle the len-th byte is issued: PKT_RDY<=0, OVR<=0, rptr<=0, -> IDLE.
//      RD while PKT_RDY=0: ignored, QV stays 0.
//  Timeout: counter cleared on every STB and in IDLE/READY; increments in LEN/PAY/CHK.
//    When it reaches TIMEOUT-1 with no STB: ERR code 00, -> IDLE.
//    STB in the same cycle wins over timeout. Counter saturates, no wrap.
//  ERR and QV are never high for more than 1 cycle per event.
//  A frame starting right after the last read is accepted: IDLE is entered on the same edge.
//  Checksum is the XOR of LEN and all payload bytes, 8-bit.
// TESTING
//  1 AA 03 11 22 33 03, all DVD=1 -> PKT_RDY=1, LEN_OUT=3; RD x3 -> Q=11,22,33 with QV;
//    PKT_RDY=0 after the last byte, ERR never set.
//  2 AA 02 10 20 00 (expected chk 32) -> ERR pulse, code 11, PKT_RDY=0;
//    then AA 01 55 54 -> PKT_RDY=1, Q=55.
//  3 AA 02 10 with DVD=0 on the 10 -> ERR code 01, state IDLE;
//    a following 20 with DVD=1 is ignored, no ERR.
//  4 AA 00 -> ERR code 10; AA 11 (17 > MAXLEN) -> ERR code 10; AA 10 (16) accepted.
//  5 AA 03 11 then silence TIMEOUT cycles -> ERR code 00 exactly TIMEOUT-1 cycles after
//    the last STB; with TIMEOUT=8 in sim, EOR held high 20 cycles yields only 1 STB.
//  6 Good packet held, send AA -> OVR=1, packet intact; read all -> OVR=0;
//    RST=0 mid-PAY -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/rx_packet_ctrl.sv
// Frame controller behind the RS232 receiver: parses SOF/LEN/payload/CHK frames into a
// local buffer, reports framing errors and overruns, and hands whole packets to the host.
module rx_packet_ctrl #(
   parameter int          MAXLEN  = 16,
   parameter int          AW      = 4,
   parameter logic [7:0]  SOF     = 8'hAA,
   parameter int          TW      = 18,
   parameter int          TIMEOUT = 168750
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EOR,
   input  logic [7:0] D,
   input  logic       DVD,
   input  logic       RD,
   output logic [7:0] Q,
   output logic       QV,
   output logic       PKT_RDY,
   output logic [7:0] LEN_OUT,
   output logic       ERR,
   output logic [1:0] ERR_CODE,
   output logic       OVR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAY,
      S_CHK,
      S_READY
   } state_t;

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);
   localparam logic [7:0]    MAXLEN_B = 8'(MAXLEN);

   localparam logic [1:0] E_TIMEOUT = 2'b00;
   localparam logic [1:0] E_PARITY  = 2'b01;
   localparam logic [1:0] E_LENGTH  = 2'b10;
   localparam logic [1:0] E_CHKSUM  = 2'b11;

   state_t          state_q, state_n;
   logic            eor_d;
   logic            stb;
   logic [7:0]      len_q;
   logic [7:0]      acc_q;
   logic [AW-1:0]   wptr_q;
   logic [AW-1:0]   rptr_q;
   logic [TW-1:0]   tcnt_q;
   logic [7:0]      mem [MAXLEN];

   logic            err_n;
   logic [1:0]      code_n;
   logic            load_len;
   logic            pay_wr;
   logic            chk_ok;
   logic            rd_fire;
   logic            rd_last;
   logic            ovr_set;
   logic            t_hit;
   logic            in_frame;

   assign stb      = EOR & ~eor_d;
   assign in_frame = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
   // Timeout fires on the edge where the counter would reach TIMEOUT-1; a strobe wins.
   assign t_hit    = in_frame && !stb && (tcnt_q == TO_LAST);

   always_ff @(posedge CLK) begin
      if (!RST) state_q <= S_IDLE;
      else      state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      err_n    = 1'b0;
      code_n   = E_TIMEOUT;
      load_len = 1'b0;
      pay_wr   = 1'b0;
      chk_ok   = 1'b0;
      rd_fire  = 1'b0;
      rd_last  = 1'b0;
      ovr_set  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (stb && DVD && (D == SOF)) state_n = S_LEN;
         end
         S_LEN: begin
            if (stb) begin
               if (!DVD) begin
                  err_n = 1'b1; code_n = E_PARITY; state_n = S_IDLE;
               end else if ((D >= 8'd1) && (D <= MAXLEN_B)) begin
                  load_len = 1'b1; state_n = S_PAY;
               end else begin
                  err_n = 1'b1; code_n = E_LENGTH; state_n = S_IDLE;
               end
            end else if (t_hit) begin
               err_n = 1'b1; code_n = E_TIMEOUT; state_n = S_IDLE;
            end
         end
         S_PAY: begin
            if (stb) begin
               if (!DVD) begin
                  err_n = 1'b1; code_n = E_PARITY; state_n = S_IDLE;
               end else begin
                  pay_wr = 1'b1;
                  if (8'(wptr_q) == len_q - 8'd1) state_n = S_CHK;
               end
            end else if (t_hit) begin
               err_n = 1'b1; code_n = E_TIMEOUT; state_n = S_IDLE;
            end
         end
         S_CHK: begin
            if (stb) begin
               if (!DVD) begin
                  err_n = 1'b1; code_n = E_PARITY; state_n = S_IDLE;
               end else if (D == acc_q) begin
                  chk_ok = 1'b1; state_n = S_READY;
               end else begin
                  err_n = 1'b1; code_n = E_CHKSUM; state_n = S_IDLE;
               end
            end else if (t_hit) begin
               err_n = 1'b1; code_n = E_TIMEOUT; state_n = S_IDLE;
            end
         end
         S_READY: begin
            ovr_set = stb;
            if (RD) begin
               rd_fire = 1'b1;
               if (8'(rptr_q) == len_q - 8'd1) begin
                  rd_last = 1'b1; state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         eor_d    <= 1'b0;
         tcnt_q   <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         Q        <= '0;
         QV       <= 1'b0;
         PKT_RDY  <= 1'b0;
         LEN_OUT  <= '0;
         ERR      <= 1'b0;
         ERR_CODE <= E_TIMEOUT;
         OVR      <= 1'b0;
      end else begin
         eor_d <= EOR;
         ERR   <= err_n;
         QV    <= rd_fire;
         if (err_n) ERR_CODE <= code_n;

         if (stb || !in_frame)       tcnt_q <= '0;
         else if (tcnt_q != '1)      tcnt_q <= tcnt_q + TW'(1);

         if (load_len) begin
            len_q  <= D;
            acc_q  <= D;
            wptr_q <= '0;
         end
         if (pay_wr) begin
            acc_q  <= acc_q ^ D;
            wptr_q <= wptr_q + AW'(1);
         end
         if (chk_ok) begin
            PKT_RDY <= 1'b1;
            LEN_OUT <= len_q;
         end
         if (ovr_set) OVR <= 1'b1;
         if (rd_fire) begin
            Q      <= mem[rptr_q];
            rptr_q <= rptr_q + AW'(1);
         end
         // Draining the last byte releases the buffer, so it also clears the overrun flag.
         if (rd_last) begin
            PKT_RDY <= 1'b0;
            LEN_OUT <= '0;
            OVR     <= 1'b0;
            rptr_q  <= '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (pay_wr) mem[wptr_q] <= D;
   end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl: stimulus pushes expected bytes, error codes and
// packet lengths; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rx_packet_ctrl;

   localparam int TO = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EOR = 1'b0;
   logic [7:0] D   = 8'h00;
   logic       DVD = 1'b0;
   logic       RD  = 1'b0;
   logic [7:0] Q;
   logic       QV;
   logic       PKT_RDY;
   logic [7:0] LEN_OUT;
   logic       ERR;
   logic [1:0] ERR_CODE;
   logic       OVR;

   rx_packet_ctrl #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .EOR(EOR), .D(D), .DVD(DVD), .RD(RD),
      .Q(Q), .QV(QV), .PKT_RDY(PKT_RDY), .LEN_OUT(LEN_OUT),
      .ERR(ERR), .ERR_CODE(ERR_CODE), .OVR(OVR)
   );

   always #5 CLK = ~CLK;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_stb = 0;
   int          err_cyc  = 0;
   logic [7:0]  exp_q   [$];
   logic [1:0]  exp_err [$];
   logic [7:0]  exp_pkt [$];
   logic        err_prev = 1'b0;
   logic        pkt_prev = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s unexpected output actual=%0h required=none", name, act);
   endtask

   // Monitor: decoupled from stimulus, compares DUT outputs against the queues.
   always @(negedge CLK) begin
      if (QV) begin
         if (exp_q.size() == 0) unexpected("q", {24'd0, Q});
         else chk("q", {24'd0, Q}, {24'd0, exp_q.pop_front()});
      end
      if (ERR) begin
         err_cyc = cyc;
         if (err_prev) unexpected("err_width", 32'd2);
         if (exp_err.size() == 0) unexpected("err_code", {30'd0, ERR_CODE});
         else chk("err_code", {30'd0, ERR_CODE}, {30'd0, exp_err.pop_front()});
      end
      if (PKT_RDY && !pkt_prev) begin
         if (exp_pkt.size() == 0) unexpected("len_out", {24'd0, LEN_OUT});
         else chk("len_out", {24'd0, LEN_OUT}, {24'd0, exp_pkt.pop_front()});
      end
      err_prev = ERR;
      pkt_prev = PKT_RDY;
   end

   task automatic send_byte(input logic [7:0] d, input logic dvd);
      @(posedge CLK); #1;
      D = d; DVD = dvd; EOR = 1'b1;
      @(posedge CLK); #1;
      last_stb = cyc;
      @(posedge CLK); #1;
      EOR = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic read_n(input int n);
      @(posedge CLK); #1;
      RD = 1'b1;
      repeat (n) @(posedge CLK);
      #1;
      RD = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      idle(3);
      chk("reset_outputs", {13'd0, Q, QV, PKT_RDY, LEN_OUT, ERR, ERR_CODE, OVR}, 32'd0);
      RST = 1'b1;
      idle(2);

      // 1: good 3-byte packet, chk = 03^11^22^33 = 03
      exp_pkt.push_back(8'd3);
      send_byte(8'hAA, 1'b1); send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
      send_byte(8'h03, 1'b1);
      chk("t1_pkt_rdy", {31'd0, PKT_RDY}, 32'd1);
      chk("t1_len_out", {24'd0, LEN_OUT}, 32'd3);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      read_n(3);
      chk("t1_pkt_rdy_after", {31'd0, PKT_RDY}, 32'd0);
      read_n(3);   // RD with no packet held must produce no QV

      // 2: bad checksum (needs 32), then good 1-byte packet (01^55 = 54)
      exp_err.push_back(2'b11);
      send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
      chk("t2_pkt_rdy_bad", {31'd0, PKT_RDY}, 32'd0);
      exp_pkt.push_back(8'd1); exp_q.push_back(8'h55);
      send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h55, 1'b1); send_byte(8'h54, 1'b1);
      read_n(1);

      // 3: parity error in payload, a following good-parity byte is ignored in IDLE
      exp_err.push_back(2'b01);
      send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b1);
      idle(4);
      chk("t3_err_code_held", {30'd0, ERR_CODE}, 32'd1);
      exp_pkt.push_back(8'd1); exp_q.push_back(8'h77);
      send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h77, 1'b1); send_byte(8'h76, 1'b1);
      read_n(1);

      // 4: length boundaries 0 and 17 rejected, 16 accepted
      exp_err.push_back(2'b10);
      send_byte(8'hAA, 1'b1); send_byte(8'h00, 1'b1);
      exp_err.push_back(2'b10);
      send_byte(8'hAA, 1'b1); send_byte(8'h11, 1'b1);
      exp_pkt.push_back(8'd16);
      send_byte(8'hAA, 1'b1); send_byte(8'h10, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         send_byte(8'(i), 1'b1);
         exp_q.push_back(8'(i));
      end
      send_byte(8'h00, 1'b1);   // 10 ^ (01^02^...^10) = 10 ^ 10 = 00
      chk("t4_len16", {24'd0, LEN_OUT}, 32'd16);
      read_n(16);

      // 5: inter-byte timeout, then a long EOR level giving only one strobe
      exp_err.push_back(2'b00);
      send_byte(8'hAA, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h11, 1'b1);
      idle(12);
      chk("t5_timeout_latency", 32'(err_cyc - last_stb), 32'(TO - 1));
      exp_err.push_back(2'b00);
      @(posedge CLK); #1;
      D = 8'hAA; DVD = 1'b1; EOR = 1'b1;
      idle(20);
      EOR = 1'b0;
      idle(10);

      // 6: overrun while a packet is held, cleared by draining; reset mid-frame
      exp_pkt.push_back(8'd2);
      send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1); send_byte(8'h64, 1'b1);
      send_byte(8'hAA, 1'b1);
      chk("t6_ovr_set", {31'd0, OVR}, 32'd1);
      chk("t6_pkt_intact", {23'd0, PKT_RDY, LEN_OUT}, {23'd0, 1'b1, 8'd2});
      exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
      read_n(2);
      chk("t6_ovr_cleared", {31'd0, OVR}, 32'd0);
      send_byte(8'hAA, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h01, 1'b1);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("t6_reset_outputs", {13'd0, Q, QV, PKT_RDY, LEN_OUT, ERR, ERR_CODE, OVR}, 32'd0);
      RST = 1'b1;
      exp_pkt.push_back(8'd1); exp_q.push_back(8'h42);
      send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h42, 1'b1); send_byte(8'h43, 1'b1);
      read_n(1);

      idle(5);
      chk("left_q",   32'(exp_q.size()),   32'd0);
      chk("left_err", 32'(exp_err.size()), 32'd0);
      chk("left_pkt", 32'(exp_pkt.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
